// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Constants and types shared by the boot sequencer and its testbench.
//   - boot_state_e   : sequencer state encoding
//   - BOOT_BYTE_W    : stream byte width
//   - BOOT_FIELD_W   : width of the header, data-word and checksum fields
//   - BOOT_MAX_WORDS : largest image accepted at the default address width
//   - count_ok()     : word-count range check applied to the header
// Optional feature macro used by the design: BOOT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam int BOOT_BYTE_W    = 8;
    localparam int BOOT_FIELD_W   = 16;
    localparam int BOOT_ADDR_W    = 15;
    localparam int BOOT_MAX_WORDS = 2 ** BOOT_ADDR_W;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR_HI  = 4'd1,
        ST_HDR_LO  = 4'd2,
        ST_DAT_HI  = 4'd3,
        ST_DAT_LO  = 4'd4,
        ST_CHK_HI  = 4'd5,
        ST_CHK_LO  = 4'd6,
        ST_RELEASE = 4'd7,
        ST_RUN     = 4'd8,
        ST_ERROR   = 4'd9
    } boot_state_e;

    // A usable image has at least one word and fits the instruction memory.
    function automatic logic count_ok(input logic [BOOT_FIELD_W-1:0] n,
                                      input int unsigned            max_words);
        return (n != '0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/boot_csum.sv
// -----------------------------------------------------------------------------
// boot_csum
// Running 16-bit sum (mod 2^16) of the image data words, used to verify the
// trailing checksum field. Only instantiated when BOOT_CHECKSUM_EN is defined.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   clr_i    : zero the sum (start of a new load)
//   add_en_i : add word_i into the sum this cycle
//   word_i   : data word to accumulate
//   sum_o    : current sum (registered)
// -----------------------------------------------------------------------------
module boot_csum
    import boot_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clr_i,
    input  logic                    add_en_i,
    input  logic [BOOT_FIELD_W-1:0] word_i,
    output logic [BOOT_FIELD_W-1:0] sum_o
);

    logic [BOOT_FIELD_W-1:0] sum_q;
    logic [BOOT_FIELD_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_en_i) begin
            sum_d = sum_q + word_i;  // wraps naturally: mod 2^16
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Boot sequencer for the Hack CPU. Holds the CPU in reset, receives a program
// image as a big-endian byte stream (word count N, N data words, optional
// checksum), writes word k to instruction-memory address k, then releases
// the CPU reset.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the trailing checksum field
// and its verification).
// Ports:
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   start_i      : one-cycle pulse starting a load (from IDLE, RUN or ERROR)
//   byte_valid_i : stream byte valid
//   byte_data_i  : stream byte
//   byte_ready_o : a byte is accepted when byte_valid_i & byte_ready_o
//   imem_wr_en_o : instruction-memory write strobe (one cycle per word)
//   imem_addr_o  : write address
//   imem_data_o  : write data
//   cpu_reset_o  : CPU reset, low only while the loaded program runs
//   busy_o       : load in progress
//   done_o       : image loaded, CPU running
//   error_o      : image rejected, CPU held in reset
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   byte_valid_i,
    input  logic [BOOT_BYTE_W-1:0] byte_data_i,
    output logic                   byte_ready_o,
    output logic                   imem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [DATA_WIDTH-1:0]  imem_data_o,
    output logic                   cpu_reset_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);

    // Equals BOOT_MAX_WORDS at the default address width.
    localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

    boot_state_e             state_q, state_d;
    logic [BOOT_BYTE_W-1:0]  hi_q, hi_d;             // high byte of current field
    logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d; // address of next word
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d; // N-1

    logic                    ready_q, ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0]   imem_data_q, imem_data_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    accept;
    logic [BOOT_FIELD_W-1:0] rx_word;

    assign accept  = byte_valid_i & ready_q;
    assign rx_word = {hi_q, byte_data_i};

`ifdef BOOT_CHECKSUM_EN
    logic                    csum_clr;
    logic                    csum_add;
    logic [BOOT_FIELD_W-1:0] csum_sum;

    boot_csum u_csum (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (csum_clr),
        .add_en_i (csum_add),
        .word_i   (rx_word),
        .sum_o    (csum_sum)
    );
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        addr_cnt_d  = addr_cnt_q;
        last_addr_d = last_addr_q;
        wr_en_d     = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
`ifdef BOOT_CHECKSUM_EN
        csum_clr    = 1'b0;
        csum_add    = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_HDR_HI;
                    addr_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
                    csum_clr   = 1'b1;
`endif
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    hi_d    = byte_data_i;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    if (!count_ok(rx_word, MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        // N is in 1..2^ADDR_WIDTH, so N-1 always fits.
                        last_addr_d = ADDR_WIDTH'(rx_word - 16'd1);
                        state_d     = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    hi_d    = byte_data_i;
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    imem_addr_d = addr_cnt_q;
                    imem_data_d = DATA_WIDTH'(rx_word);
                    addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
`ifdef BOOT_CHECKSUM_EN
                    csum_add    = 1'b1;
`endif
                    if (addr_cnt_q == last_addr_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = ST_CHK_HI;
`else
                        state_d = ST_RELEASE;
`endif
                    end else begin
                        state_d = ST_DAT_HI;
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK_HI: begin
                if (accept) begin
                    hi_d    = byte_data_i;
                    state_d = ST_CHK_LO;
                end
            end
            ST_CHK_LO: begin
                // The last data word was added on its own handshake edge,
                // so csum_sum already covers the whole image here.
                if (accept) begin
                    state_d = (rx_word == csum_sum) ? ST_RELEASE : ST_ERROR;
                end
            end
`endif
            // One-cycle gap lets the final write commit before the CPU
            // leaves reset and fetches address 0.
            ST_RELEASE: state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so each
        // output flop tracks the state flop cycle for cycle.
        ready_d     = state_d inside {ST_HDR_HI, ST_HDR_LO, ST_DAT_HI,
                                      ST_DAT_LO, ST_CHK_HI, ST_CHK_LO};
        busy_d      = ready_d || (state_d == ST_RELEASE);
        cpu_reset_d = (state_d != ST_RUN);
        done_d      = (state_d == ST_RUN);
        error_d     = (state_d == ST_ERROR);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            addr_cnt_q  <= '0;
            last_addr_q <= '0;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_cnt_q  <= addr_cnt_d;
            last_addr_q <= last_addr_d;
            ready_q     <= ready_d;
            wr_en_q     <= wr_en_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_wr_en_o = wr_en_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_data_o  = imem_data_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
